cordic_req_seq: RTL

CORDIC_REQ_SEQ -- requirements
Module: cordic_req_seq

---
 rtl/cordic_req_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cordic_req_seq.sv
// Request sequencer for a multi-cycle CORDIC core: queues angle requests,
// issues them one at a time, blanks stale done, times out, and holds results.
module cordic_req_seq #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_theta,
  input  logic       req_s_c,
  output logic       cdc_start,
  output logic [7:0] cdc_theta,
  output logic       cdc_s_c,
  input  logic       cdc_done,
  input  logic [7:0] cdc_value,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_value,
  output logic       res_s_c,
  output logic       res_err
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ENTRY_W = DATA_W + 1;
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned WCNT_W  = 16;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_e;

  state_e              state_q, state_d;
  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                cdc_start_q, cdc_start_d;
  logic [DATA_W-1:0]   cdc_theta_q, cdc_theta_d;
  logic                cdc_s_c_q, cdc_s_c_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_value_q, res_value_d;
  logic                res_s_c_q, res_s_c_d;
  logic                res_err_q, res_err_d;
  logic                push_c;
  logic                pop_c;

  // FIFO bookkeeping and sequencer next-state / next-output logic
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    wait_cnt_d  = wait_cnt_q;
    cdc_start_d = 1'b0;
    cdc_theta_d = cdc_theta_q;
    cdc_s_c_d   = cdc_s_c_q;
    res_valid_d = res_valid_q;
    res_value_d = res_value_q;
    res_s_c_d   = res_s_c_q;
    res_err_d   = res_err_q;
    push_c      = req_valid && req_ready_q;
    pop_c       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop_c                    = 1'b1;
          {cdc_s_c_d, cdc_theta_d} = mem_q[rd_ptr_q];
          cdc_start_d              = 1'b1;
          state_d                  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // done seen in the first WAIT cycle may belong to the previous op
        if ((wait_cnt_q != '0) && cdc_done) begin
          res_value_d = cdc_value;
          res_err_d   = 1'b0;
          res_s_c_d   = cdc_s_c_q;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
          res_value_d = '0;
          res_err_d   = 1'b1;
          res_s_c_d   = cdc_s_c_q;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    req_ready_d = (cnt_d != CNT_W'(DEPTH));
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      wait_cnt_q  <= '0;
      req_ready_q <= 1'b0;
      cdc_start_q <= 1'b0;
      cdc_theta_q <= '0;
      cdc_s_c_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_value_q <= '0;
      res_s_c_q   <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      req_ready_q <= req_ready_d;
      cdc_start_q <= cdc_start_d;
      cdc_theta_q <= cdc_theta_d;
      cdc_s_c_q   <= cdc_s_c_d;
      res_valid_q <= res_valid_d;
      res_value_q <= res_value_d;
      res_s_c_q   <= res_s_c_d;
      res_err_q   <= res_err_d;
    end
  end

  // FIFO storage; contents are don't-care once pointers are cleared
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= {req_s_c, req_theta};
  end

  assign req_ready = req_ready_q;
  assign cdc_start = cdc_start_q;
  assign cdc_theta = cdc_theta_q;
  assign cdc_s_c   = cdc_s_c_q;
  assign res_valid = res_valid_q;
  assign res_value = res_value_q;
  assign res_s_c   = res_s_c_q;
  assign res_err   = res_err_q;

endmodule
